atm_keypad_frontend: RTL and testbench

ATM_KEYPAD_FRONTEND -- requirements
Module: atm_keypad_frontend

---
 rtl/atm_keypad_frontend.sv | 278 +++++++++++++++++++++++++++
 tb/tb_atm_keypad_frontend.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_keypad_frontend.sv
// ATM keypad front end.
// Collects digits from a keypad into a decimal buffer, walks the customer
// through card -> PIN -> menu -> (amount / destination) entry, then holds a
// request toward the ATM until the ATM answers, and shows the answer.
//
// Handshake: req_valid is a level that is high exactly while the FSM sits in
// REQUEST, and the request fields (account_num, pin, dest_acc, amount,
// menu_option) are stable for that whole time. The ATM answers with a
// one-cycle rsp_valid strobe carrying rsp_error/rsp_balance. There is no
// backpressure on the answer: a strobe in REQUEST is always taken, and a
// strobe in any other state is dropped.
module atm_keypad_frontend #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        rsp_valid,
    input  logic        rsp_error,
    input  logic [19:0] rsp_balance,
    output logic [11:0] account_num,
    output logic [13:0] pin,
    output logic [11:0] dest_acc,
    output logic [19:0] amount,
    output logic [2:0]  menu_option,
    output logic        req_valid,
    output logic        exit_req,
    output logic        entry_error,
    output logic        timeout,
    output logic [19:0] disp_balance,
    output logic        disp_error,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_CARD    = 3'd0,
        S_PIN     = 3'd1,
        S_MENU    = 3'd2,
        S_AMOUNT  = 3'd3,
        S_DEST    = 3'd4,
        S_REQUEST = 3'd5,
        S_RESULT  = 3'd6
    } state_t;

    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_CLEAR  = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    // Idle counter wide enough to hold TIMEOUT_CYCLES.
    localparam int            CW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] IDLE_ONE  = CW'(1);

    state_t        state_q, state_d;
    logic [19:0]   buf_q, buf_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [CW-1:0] idle_q, idle_d;
    logic [11:0]   account_q, account_d;
    logic [13:0]   pin_q, pin_d;
    logic [11:0]   dest_q, dest_d;
    logic [19:0]   amount_q, amount_d;
    logic [2:0]    menu_q, menu_d;
    logic          exit_q, exit_d;
    logic          err_q, err_d;
    logic          tmo_q, tmo_d;
    logic [19:0]   disp_bal_q, disp_bal_d;
    logic          disp_err_q, disp_err_d;

    logic [2:0]    max_cnt;
    logic [19:0]   buf_app;
    logic          is_digit;
    logic          idle_hit;
    logic          do_cancel;

    // Largest digit count the current entry field accepts; 0 means digits
    // are meaningless here and get dropped.
    always_comb begin
        max_cnt = 3'd0;
        case (state_q)
            S_CARD, S_PIN, S_DEST: max_cnt = 3'd4;
            S_AMOUNT:              max_cnt = 3'd6;
            S_MENU:                max_cnt = 3'd1;
            default:               max_cnt = 3'd0;
        endcase
    end

    // Buffer with the pressed digit appended. At most six digits are ever
    // accepted, so 999999 is the largest value and 20 bits never overflow.
    assign buf_app  = (buf_q * 20'd10) + {16'd0, key_code};
    assign is_digit = (key_code <= 4'd9);

    // Idle counter: any key restarts it, it is parked at zero in CARD and
    // REQUEST, and it fires on the cycle it would reach TIMEOUT_CYCLES.
    // Because a key forces the restart branch, a key arriving in the very
    // cycle the timeout would fire always wins.
    always_comb begin
        idle_d   = idle_q + IDLE_ONE;
        idle_hit = 1'b0;
        if (state_q == S_CARD || state_q == S_REQUEST || key_valid) begin
            idle_d = '0;
        end else if (idle_q == IDLE_LAST) begin
            idle_hit = 1'b1;
            idle_d   = '0;
        end
    end

    // Session FSM next state, request fields, display capture and pulses.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        account_d  = account_q;
        pin_d      = pin_q;
        dest_d     = dest_q;
        amount_d   = amount_q;
        menu_d     = menu_q;
        disp_bal_d = disp_bal_q;
        disp_err_d = disp_err_q;
        exit_d     = 1'b0;
        err_d      = 1'b0;
        tmo_d      = 1'b0;
        do_cancel  = 1'b0;

        if (idle_hit) begin
            do_cancel = 1'b1;
            tmo_d     = 1'b1;
        end else if (state_q == S_REQUEST) begin
            // Waiting on the ATM: every key, CANCEL included, is dropped.
            if (rsp_valid) begin
                disp_bal_d = rsp_balance;
                disp_err_d = rsp_error;
                state_d    = S_RESULT;
            end
        end else if (key_valid) begin
            if (key_code == KEY_CANCEL) begin
                do_cancel = 1'b1;
            end else if (key_code == KEY_CLEAR) begin
                buf_d = '0;
                cnt_d = '0;
            end else if (key_code == KEY_ENTER) begin
                if (state_q == S_RESULT) begin
                    // Acknowledge the result and offer a new transaction
                    // on the same card.
                    state_d  = S_MENU;
                    amount_d = '0;
                    dest_d   = '0;
                    menu_d   = '0;
                end else if (cnt_q != 3'd0) begin
                    case (state_q)
                        S_CARD: begin
                            if (buf_q <= 20'd4095) begin
                                account_d = buf_q[11:0];
                                state_d   = S_PIN;
                            end else begin
                                err_d = 1'b1;
                                buf_d = '0;
                                cnt_d = '0;
                            end
                        end
                        S_PIN: begin
                            pin_d   = buf_q[13:0];
                            state_d = S_MENU;
                        end
                        S_MENU: begin
                            menu_d = buf_q[2:0];
                            case (buf_q)
                                20'd3:        state_d = S_REQUEST;
                                20'd4, 20'd5: state_d = S_AMOUNT;
                                20'd6:        state_d = S_DEST;
                                default: begin
                                    err_d = 1'b1;
                                    buf_d = '0;
                                    cnt_d = '0;
                                end
                            endcase
                        end
                        S_DEST: begin
                            if (buf_q <= 20'd4095) begin
                                dest_d  = buf_q[11:0];
                                state_d = S_AMOUNT;
                            end else begin
                                err_d = 1'b1;
                                buf_d = '0;
                                cnt_d = '0;
                            end
                        end
                        S_AMOUNT: begin
                            if (buf_q != 20'd0) begin
                                amount_d = buf_q;
                                state_d  = S_REQUEST;
                            end else begin
                                err_d = 1'b1;
                                buf_d = '0;
                                cnt_d = '0;
                            end
                        end
                        default: begin
                            state_d = state_q;
                        end
                    endcase
                end
            end else if (is_digit && (cnt_q < max_cnt)) begin
                buf_d = buf_app;
                cnt_d = cnt_q + 3'd1;
            end
            // Codes D-F fall through untouched (they still restart idle).
        end

        // CANCEL and timeout both end the session and wipe the request.
        if (do_cancel) begin
            exit_d    = 1'b1;
            account_d = '0;
            pin_d     = '0;
            dest_d    = '0;
            amount_d  = '0;
            menu_d    = '0;
            buf_d     = '0;
            cnt_d     = '0;
            state_d   = S_CARD;
        end

        // Every field starts empty when its state is entered.
        if (state_d != state_q) begin
            buf_d = '0;
            cnt_d = '0;
        end
    end

    // State and output registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_CARD;
            buf_q      <= '0;
            cnt_q      <= '0;
            idle_q     <= '0;
            account_q  <= '0;
            pin_q      <= '0;
            dest_q     <= '0;
            amount_q   <= '0;
            menu_q     <= '0;
            exit_q     <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= 1'b0;
            disp_bal_q <= '0;
            disp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            idle_q     <= idle_d;
            account_q  <= account_d;
            pin_q      <= pin_d;
            dest_q     <= dest_d;
            amount_q   <= amount_d;
            menu_q     <= menu_d;
            exit_q     <= exit_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
            disp_bal_q <= disp_bal_d;
            disp_err_q <= disp_err_d;
        end
    end

    assign account_num  = account_q;
    assign pin          = pin_q;
    assign dest_acc     = dest_q;
    assign amount       = amount_q;
    assign menu_option  = menu_q;
    assign req_valid    = (state_q == S_REQUEST);
    assign exit_req     = exit_q;
    assign entry_error  = err_q;
    assign timeout      = tmo_q;
    assign disp_balance = disp_bal_q;
    assign disp_error   = disp_err_q;
    assign state        = state_q;

endmodule

// File: tb/tb_atm_keypad_frontend.sv
// Self-checking bench for atm_keypad_frontend (TIMEOUT_CYCLES = 16).
module tb_atm_keypad_frontend;

  localparam int TO = 16;
  localparam logic [3:0] K_ENT = 4'hA;
  localparam logic [3:0] K_CLR = 4'hB;
  localparam logic [3:0] K_CAN = 4'hC;

  logic        clk;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        rsp_valid;
  logic        rsp_error;
  logic [19:0] rsp_balance;
  logic [11:0] account_num;
  logic [13:0] pin;
  logic [11:0] dest_acc;
  logic [19:0] amount;
  logic [2:0]  menu_option;
  logic        req_valid;
  logic        exit_req;
  logic        entry_error;
  logic        timeout;
  logic [19:0] disp_balance;
  logic        disp_error;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  logic [60:0] exp_q[$];
  logic [60:0] sb_v;
  logic        req_prev;
  logic [60:0] req_pkt;
  logic [27:0] stat_bus;

  typedef struct {
    logic [3:0]  key;
    logic [2:0]  st;
    logic        err;
    logic        ext;
    logic [11:0] acc;
  } vec_t;

  vec_t tbl[27];

  assign req_pkt  = {account_num, pin, dest_acc, amount, menu_option};
  assign stat_bus = {req_valid, exit_req, entry_error, timeout, disp_balance, disp_error, state};

  atm_keypad_frontend #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .reset(reset),
    .key_valid(key_valid),
    .key_code(key_code),
    .rsp_valid(rsp_valid),
    .rsp_error(rsp_error),
    .rsp_balance(rsp_balance),
    .account_num(account_num),
    .pin(pin),
    .dest_acc(dest_acc),
    .amount(amount),
    .menu_option(menu_option),
    .req_valid(req_valid),
    .exit_req(exit_req),
    .entry_error(entry_error),
    .timeout(timeout),
    .disp_balance(disp_balance),
    .disp_error(disp_error),
    .state(state)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=no_finish want=finish");
    $fatal(1, "watchdog expired");
  end

  // checking helpers
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [60:0] pkt(input logic [11:0] a, input logic [13:0] p,
                                      input logic [11:0] d, input logic [19:0] m,
                                      input logic [2:0] o);
    return {a, p, d, m, o};
  endfunction

  // scoreboard: each new request is popped against the queue
  always @(negedge clk) begin
    if (req_valid === 1'b1 && req_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_req: got=%0h want=none", req_pkt);
      end else begin
        sb_v = exp_q.pop_front();
        chk("sb_req", 64'(req_pkt), 64'(sb_v));
      end
    end
    req_prev <= req_valid;
  end

  // driver tasks (called at a negedge, return at the next negedge)
  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic respond(input logic [19:0] bal, input logic err);
    rsp_valid   = 1'b1;
    rsp_balance = bal;
    rsp_error   = err;
    @(negedge clk);
    rsp_valid   = 1'b0;
    rsp_balance = 20'd0;
    rsp_error   = 1'b0;
  endtask

  task automatic wait_tmo(output int n);
    n = 0;
    while (timeout !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic set_v(input int i, input logic [3:0] k, input logic [2:0] s,
                       input logic e, input logic x, input logic [11:0] a);
    tbl[i] = '{key: k, st: s, err: e, ext: x, acc: a};
  endtask

  // stimulus
  initial begin
    int n;
    int pulses;

    reset       = 1'b1;
    key_valid   = 1'b0;
    key_code    = 4'h0;
    rsp_valid   = 1'b0;
    rsp_error   = 1'b0;
    rsp_balance = 20'd0;

    // key, state, entry_error, exit_req, account_num after each key
    set_v( 0, 4'd9,  3'd0, 1'b0, 1'b0, 12'd0);
    set_v( 1, 4'd9,  3'd0, 1'b0, 1'b0, 12'd0);
    set_v( 2, 4'd9,  3'd0, 1'b0, 1'b0, 12'd0);
    set_v( 3, 4'd9,  3'd0, 1'b0, 1'b0, 12'd0);
    set_v( 4, K_ENT, 3'd0, 1'b1, 1'b0, 12'd0);
    set_v( 5, K_ENT, 3'd0, 1'b0, 1'b0, 12'd0);
    set_v( 6, 4'd2,  3'd0, 1'b0, 1'b0, 12'd0);
    set_v( 7, 4'd7,  3'd0, 1'b0, 1'b0, 12'd0);
    set_v( 8, 4'd4,  3'd0, 1'b0, 1'b0, 12'd0);
    set_v( 9, 4'd9,  3'd0, 1'b0, 1'b0, 12'd0);
    set_v(10, 4'd5,  3'd0, 1'b0, 1'b0, 12'd0);
    set_v(11, K_ENT, 3'd1, 1'b0, 1'b0, 12'd2749);
    set_v(12, 4'd0,  3'd1, 1'b0, 1'b0, 12'd2749);
    set_v(13, 4'd0,  3'd1, 1'b0, 1'b0, 12'd2749);
    set_v(14, 4'd0,  3'd1, 1'b0, 1'b0, 12'd2749);
    set_v(15, 4'd1,  3'd1, 1'b0, 1'b0, 12'd2749);
    set_v(16, K_ENT, 3'd2, 1'b0, 1'b0, 12'd2749);
    set_v(17, 4'd8,  3'd2, 1'b0, 1'b0, 12'd2749);
    set_v(18, K_ENT, 3'd2, 1'b1, 1'b0, 12'd2749);
    set_v(19, 4'd7,  3'd2, 1'b0, 1'b0, 12'd2749);
    set_v(20, K_CLR, 3'd2, 1'b0, 1'b0, 12'd2749);
    set_v(21, K_ENT, 3'd2, 1'b0, 1'b0, 12'd2749);
    set_v(22, 4'd3,  3'd2, 1'b0, 1'b0, 12'd2749);
    set_v(23, K_ENT, 3'd5, 1'b0, 1'b0, 12'd2749);
    set_v(24, K_CAN, 3'd5, 1'b0, 1'b0, 12'd2749);
    set_v(25, 4'd1,  3'd5, 1'b0, 1'b0, 12'd2749);
    set_v(26, K_ENT, 3'd5, 1'b0, 1'b0, 12'd2749);

    repeat (2) @(negedge clk);
    chk("rst_req_fields", 64'(req_pkt), 64'd0);
    chk("rst_status", 64'(stat_bus), 64'd0);
    reset = 1'b0;

    // response outside REQUEST is dropped
    respond(20'd777, 1'b1);
    chk("rsp_ignored_card", 64'(stat_bus), 64'd0);

    // table: card error, card/pin entry, menu error/clear, request, keys in REQUEST
    exp_q.push_back(pkt(12'd2749, 14'd1, 12'd0, 20'd0, 3'd3));
    for (int i = 0; i < 27; i++) begin
      press(tbl[i].key);
      chk($sformatf("tbl%0d_state", i), 64'(state), 64'(tbl[i].st));
      chk($sformatf("tbl%0d_err", i), 64'(entry_error), 64'(tbl[i].err));
      chk($sformatf("tbl%0d_exit", i), 64'(exit_req), 64'(tbl[i].ext));
      chk($sformatf("tbl%0d_acc", i), 64'(account_num), 64'(tbl[i].acc));
    end
    chk("t1_fields", 64'(req_pkt), 64'(pkt(12'd2749, 14'd1, 12'd0, 20'd0, 3'd3)));
    chk("t1_req_valid", 64'(req_valid), 64'd1);
    respond(20'd1000, 1'b0);
    chk("t1_state_result", 64'(state), 64'd6);
    chk("t1_disp_balance", 64'(disp_balance), 64'd1000);
    chk("t1_disp_error", 64'(disp_error), 64'd0);
    chk("t1_req_dropped", 64'(req_valid), 64'd0);

    // transfer: result->menu clears, dest error, dest/amount, keys in REQUEST
    press(K_ENT);
    chk("t2_menu", 64'(state), 64'd2);
    chk("t2_menu_cleared", 64'(menu_option), 64'd0);
    press(4'd6); press(K_ENT);
    chk("t2_dest", 64'(state), 64'd4);
    press(4'd5); press(4'd0); press(4'd0); press(4'd0); press(K_ENT);
    chk("t2_dest_err", 64'(entry_error), 64'd1);
    chk("t2_dest_stay", 64'(state), 64'd4);
    press(4'd2); press(4'd1); press(4'd7); press(4'd5); press(K_ENT);
    chk("t2_amount_state", 64'(state), 64'd3);
    chk("t2_dest_acc", 64'(dest_acc), 64'd2175);
    exp_q.push_back(pkt(12'd2749, 14'd1, 12'd2175, 20'd50, 3'd6));
    press(4'd5); press(4'd0); press(K_ENT);
    chk("t2_request", 64'(state), 64'd5);
    press(4'd9); press(K_CLR); press(K_ENT); press(K_CAN); press(4'd6); press(K_ENT);
    chk("t2_held_fields", 64'(req_pkt), 64'(pkt(12'd2749, 14'd1, 12'd2175, 20'd50, 3'd6)));
    chk("t2_held_state", 64'(state), 64'd5);
    chk("t2_no_exit", 64'(exit_req), 64'd0);
    respond(20'd12345, 1'b1);
    chk("t2_result", 64'(state), 64'd6);
    chk("t2_disp_balance", 64'(disp_balance), 64'd12345);
    chk("t2_disp_error", 64'(disp_error), 64'd1);

    // withdrawal: zero amount error, seventh digit dropped
    press(K_ENT); press(4'd4); press(K_ENT);
    chk("t3_amount", 64'(state), 64'd3);
    press(K_ENT);
    chk("t3_empty_enter", 64'(entry_error), 64'd0);
    press(4'd0); press(K_ENT);
    chk("t3_zero_err", 64'(entry_error), 64'd1);
    chk("t3_zero_stay", 64'(state), 64'd3);
    exp_q.push_back(pkt(12'd2749, 14'd1, 12'd0, 20'd123456, 3'd4));
    for (int d = 1; d <= 7; d++) press(4'(d));
    press(K_ENT);
    chk("t3_request", 64'(state), 64'd5);
    chk("t3_amount_val", 64'(amount), 64'd123456);
    respond(20'd54321, 1'b0);
    chk("t3_disp_balance", 64'(disp_balance), 64'd54321);

    // cancel from MENU
    press(K_ENT);
    chk("t4_menu", 64'(state), 64'd2);
    press(K_CAN);
    chk("t4_exit", 64'(exit_req), 64'd1);
    chk("t4_card", 64'(state), 64'd0);
    chk("t4_cleared", 64'(req_pkt), 64'd0);
    @(negedge clk);
    chk("t4_exit_width", 64'(exit_req), 64'd0);

    // key exactly at the timeout cycle wins, then timeout from PIN
    press(4'd1); press(4'd0); press(4'd0); press(K_ENT);
    chk("t5_pin_state", 64'(state), 64'd1);
    chk("t5_acc", 64'(account_num), 64'd100);
    repeat (TO - 1) @(negedge clk);
    press(4'd7);
    chk("t5_key_wins", 64'(timeout), 64'd0);
    chk("t5_still_pin", 64'(state), 64'd1);
    wait_tmo(n);
    chk("t5_idle_cycles", 64'(n), 64'd16);
    chk("t5_exit", 64'(exit_req), 64'd1);
    chk("t5_card", 64'(state), 64'd0);
    chk("t5_acc_cleared", 64'(account_num), 64'd0);
    @(negedge clk);
    chk("t5_tmo_width", 64'(timeout), 64'd0);
    chk("t5_exit_width", 64'(exit_req), 64'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (timeout === 1'b1) pulses++;
    end
    chk("t5_card_no_tmo", 64'(pulses), 64'd0);

    // timeout from MENU
    press(4'd1); press(4'd0); press(4'd0); press(K_ENT);
    press(4'd4); press(4'd2); press(K_ENT);
    chk("t6_menu", 64'(state), 64'd2);
    chk("t6_pin", 64'(pin), 64'd42);
    wait_tmo(n);
    chk("t6_idle_cycles", 64'(n), 64'd16);
    chk("t6_timeout", 64'(timeout), 64'd1);
    chk("t6_exit", 64'(exit_req), 64'd1);
    chk("t6_card", 64'(state), 64'd0);
    chk("t6_pin_cleared", 64'(pin), 64'd0);
    @(negedge clk);

    // asynchronous reset in REQUEST
    press(4'd1); press(K_ENT); press(4'd2); press(K_ENT);
    exp_q.push_back(pkt(12'd1, 14'd2, 12'd0, 20'd0, 3'd3));
    press(4'd3); press(K_ENT);
    chk("t7_request", 64'(state), 64'd5);
    #2 reset = 1'b1;
    #1;
    chk("t7_async_req_valid", 64'(req_valid), 64'd0);
    chk("t7_async_state", 64'(state), 64'd0);
    chk("t7_async_fields", 64'(req_pkt), 64'd0);
    chk("t7_async_status", 64'(stat_bus), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    press(4'd5);
    respond(20'd999, 1'b1);
    chk("t7_rsp_ignored", 64'(stat_bus), 64'd0);
    press(K_ENT);
    chk("t7_first_edge_key", 64'(state), 64'd1);
    chk("t7_acc", 64'(account_num), 64'd5);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
